tpu_instr_sequencer: RTL and testbench

- Buffers 16-bit Mini-TPU instructions from a host in a FIFO and issues them to the control unit's `instruction` input, one per cycle.
- Holds off further issue while a START-triggered array computation is running.
- Provides an abort path that issues STOP immediately and flushes the queue.
- Sits between the host/bus interface and the control unit.

---
 rtl/tpu_seq_pkg.sv | 23 ++
 rtl/tpu_instr_sequencer_fifo.sv | 81 ++++++++
 rtl/tpu_instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_tpu_instr_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types and fixed instruction words for the Mini-TPU instruction sequencer.
package tpu_seq_pkg;

  typedef enum logic [1:0] {
    OPC_START = 2'b00,
    OPC_STOP  = 2'b01,
    OPC_LOAD  = 2'b10,
    OPC_STORE = 2'b11
  } opcode_e;

  typedef enum logic {
    RUN     = 1'b0,
    COMPUTE = 1'b1
  } seq_state_e;

  localparam logic [15:0] IDLE_WORD = 16'hC000;
  localparam logic [15:0] STOP_WORD = 16'h4000;

  function automatic opcode_e get_opcode(input logic [15:0] word);
    return opcode_e'(word[15:14]);
  endfunction

endpackage

// File: rtl/tpu_instr_sequencer_fifo.sv
// Synchronous instruction FIFO with flush; push while full and pop while empty are ignored.
module seq_fifo
  import tpu_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Buffers host instructions and issues one per cycle to the control unit, holding off during START.
// Optional perf counters are built when SEQ_PERF_EN is defined.
//
// state   | meaning
// RUN     | pop and issue one queued word per cycle, idle word when empty
// COMPUTE | array busy; down-counter runs, issue resumes on its terminal cycle
module tpu_instr_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int          DEPTH          = 8,
  parameter int          COMPUTE_CYCLES = 10,
  parameter logic [15:0] IDLE_WORD      = tpu_seq_pkg::IDLE_WORD,
  parameter logic [15:0] STOP_WORD      = tpu_seq_pkg::STOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            host_instr,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   abort,
  output logic [15:0]            instruction,
  output logic                   issue_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0]            perf_busy_cycles,
  output logic [31:0]            perf_stall_cycles
`endif
);

  localparam int CNT_W = (COMPUTE_CYCLES < 2) ? 1 : $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      instr_q, instr_d;
  logic             issue_valid_q, issue_valid_d;
  logic             rdy_en_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [15:0]      fifo_rdata;
  logic             can_issue;

  // rdy_en_q keeps host_ready low during reset and for the first cycle after it.
  assign host_ready  = rdy_en_q && !fifo_full && !abort;
  assign fifo_push   = host_valid && host_ready;
  assign instruction = instr_q;
  assign issue_valid = issue_valid_q;
  assign busy        = (state_q == COMPUTE) && (cnt_q != CNT_LOAD);
  assign done        = (state_q == COMPUTE) && (cnt_q == '0);

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (host_instr),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_d       = IDLE_WORD;
    issue_valid_d = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    can_issue     = (state_q == RUN) || done;
    if (abort) begin
      instr_d       = STOP_WORD;
      issue_valid_d = 1'b1;
      fifo_flush    = 1'b1;
      cnt_d         = '0;
      state_d       = RUN;
    end else begin
      if ((state_q == COMPUTE) && !done) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (can_issue) begin
        state_d = RUN;
        cnt_d   = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          instr_d       = fifo_rdata;
          issue_valid_d = 1'b1;
          if (get_opcode(fifo_rdata) == OPC_START) begin
            state_d = COMPUTE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      instr_q       <= IDLE_WORD;
      issue_valid_q <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      issue_valid_q <= issue_valid_d;
      rdy_en_q      <= 1'b1;
    end
  end

`ifdef SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
    if (host_valid && !host_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Scoreboard bench for tpu_instr_sequencer: stimulus queues expected issue words, a monitor checks them.
module tb_tpu_instr_sequencer;

  localparam int CC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_instr = 16'h0;
  logic        host_valid = 1'b0;
  logic        abort = 1'b0;
  logic        host_ready;
  logic [15:0] instruction;
  logic        issue_valid;
  logic        busy;
  logic        done;
  logic [3:0]  fifo_count;
`ifdef SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          stall_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  tpu_instr_sequencer #(
    .DEPTH          (8),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_instr  (host_instr),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .abort       (abort),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .busy        (busy),
    .done        (done),
    .fifo_count  (fifo_count)
`ifdef SEQ_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && host_valid && !host_ready) stall_seen <= stall_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic expv);
    chk(name, 32'(act), 32'(expv));
  endtask

  // Monitor: every issued word must be the next expected one; otherwise the idle word is driven.
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %0h expected no issue at cycle %0d", instruction, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("issue_word", 32'(instruction), 32'(mon_exp));
        end
      end else begin
        chk("idle_word", 32'(instruction), 32'h0000_C000);
      end
    end
  end

  task automatic push(input logic [15:0] w);
    int n;
    n = 0;
    host_valid = 1'b1;
    host_instr = w;
    @(negedge clk);
    while (!host_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 for %0h", w);
      host_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(w);
      #1;
    end
  endtask

  task automatic wait_issue(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (issue_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL wait_issue: got no issue expected an issue within 40 cycles");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || issue_valid || busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || issue_valid || busy) begin
      bad++;
      $display("FAIL drain: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, t, n;
`ifdef SEQ_PERF_EN
    logic [31:0] s_busy, s_stall;
    int          s_seen;
`endif
    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_instr", 32'(instruction), 32'h0000_C000);
    chk_b("rst_issue_valid", issue_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk_b("rst_ready", host_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_b("ready_first_cycle", host_ready, 1'b0);
    @(negedge clk);
    chk_b("ready_after", host_ready, 1'b1);

    // Back-to-back issue
    @(posedge clk); #1;
    push(16'h8AAB);
    push(16'hB7CD);
    host_valid = 1'b0;
    wait_issue(c1);
    wait_issue(c2);
    chk("b2b_gap", 32'(c2 - c1), 32'd1);
    @(negedge clk);
    chk_b("b2b_then_idle", issue_valid, 1'b0);
    wait_drain();

    // START hold-off timing
    @(posedge clk); #1;
    push(16'h0000);
    push(16'h8011);
    host_valid = 1'b0;
    wait_issue(t);
    for (int k = 1; k <= CC + 1; k++) begin
      @(negedge clk);
      chk_b($sformatf("start_busy_T+%0d", k), busy, k <= CC);
      chk_b($sformatf("start_done_T+%0d", k), done, k == CC);
      chk_b($sformatf("start_issue_T+%0d", k), issue_valid, k == CC + 1);
    end
    wait_drain();

    // Fill to DEPTH during COMPUTE
    @(posedge clk); #1;
    push(16'h0000);
    for (int i = 0; i < 8; i++) push(16'h8100 + 16'(i));
    host_valid = 1'b1;
    host_instr = 16'h81FF;
    @(negedge clk);
    chk("fill_count", 32'(fifo_count), 32'd8);
    chk_b("fill_ready", host_ready, 1'b0);
    chk_b("fill_busy", busy, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_b("fill_done_seen", done, 1'b1);
    chk("fill_done_count", 32'(fifo_count), 32'd8);
    chk_b("fill_done_ready", host_ready, 1'b0);
    @(negedge clk);
    chk("after_done_count", 32'(fifo_count), 32'd7);
    chk_b("after_done_ready", host_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(16'h81FF);
    #1 host_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 32'(fifo_count), 32'd7);
    wait_drain();

    // Abort at T+4 with 5 queued
    @(posedge clk); #1;
    push(16'h0000);
    for (int i = 0; i < 5; i++) push(16'h8A00 + 16'(i));
    abort = 1'b1;
    host_instr = 16'h8DDD;
    @(negedge clk);
    chk_b("abort_ready", host_ready, 1'b0);
    chk_b("abort_busy_before", busy, 1'b1);
    chk("abort_count_before", 32'(fifo_count), 32'd5);
    @(posedge clk);
    #1;
    abort = 1'b0;
    host_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h4000);
    @(negedge clk);
    chk_b("abort_issue_valid", issue_valid, 1'b1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk_b("abort_busy", busy, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_b("abort_no_done", done, 1'b0);
      chk("abort_dropped_push", 32'(fifo_count), 32'd0);
    end

    // Abort held for two cycles repeats STOP
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h4000);
    @(posedge clk);
    exp_q.push_back(16'h4000);
    #1 abort = 1'b0;
    wait_drain();

    // Reset mid-stream with 3 queued during COMPUTE
    @(posedge clk); #1;
    push(16'h0000);
    for (int i = 0; i < 3; i++) push(16'h8C01 + 16'(i));
    host_valid = 1'b0;
    @(negedge clk);
    chk("midrst_count_before", 32'(fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_instr", 32'(instruction), 32'h0000_C000);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_issue_valid", issue_valid, 1'b0);
    chk_b("midrst_ready", host_ready, 1'b0);
`ifdef SEQ_PERF_EN
    chk("midrst_perf_busy", perf_busy_cycles, 32'd0);
    chk("midrst_perf_stall", perf_stall_cycles, 32'd0);
`endif
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(16'h8123);
    host_valid = 1'b0;
    wait_drain();

`ifdef SEQ_PERF_EN
    // Perf counters over one START with the queue held full
    @(negedge clk);
    s_busy = perf_busy_cycles;
    s_stall = perf_stall_cycles;
    s_seen = stall_seen;
    @(posedge clk); #1;
    push(16'h0000);
    for (int i = 0; i < 8; i++) push(16'h8200 + 16'(i));
    push(16'h82FF);
    host_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    chk("perf_busy_delta", perf_busy_cycles - s_busy, 32'd10);
    chk("perf_stall_delta", perf_stall_cycles - s_stall, 32'(stall_seen - s_seen));
    chk("perf_stall_expected", 32'(stall_seen - s_seen), 32'd4);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
